// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch unit.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Clear the byte-offset bits so a target always names a whole word.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the decoder until accepted, and follows datapath redirects.
// A redirect that lands while a request is in flight parks the FSM in DROP so
// the stale word is swallowed before fetching from the new target.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               CLK,
    input  logic               RST_N,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic               misalign,
    output logic [31:0]        instr_count
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_req;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;
    logic [ADDR_W-1:0]  r_pc_plus4;
    logic [31:0]        r_count;

    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  w_target;
    logic               w_hs;
    logic               w_capture;
    logic               w_count_inc;

    assign w_target = align_word(redirect_pc);
    // r_req is low only in HOLD and in the very first cycle out of reset,
    // so an ack seen while it is low never completes a transfer.
    assign w_hs     = r_req & imem_ack;

    // Next-state and next-PC decision; redirect is checked first in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_count_inc = 1'b0;
        case (r_state)
            FETCH: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                    // Only an unanswered request leaves stale data to swallow.
                    if (r_req && !imem_ack) begin
                        w_state_nxt = DROP;
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end else if (w_hs) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_count_inc = instr_ready;
                    w_state_nxt = FETCH;
                end else if (instr_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_count_inc = 1'b1;
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_target;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (w_hs) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: begin
                w_state_nxt = FETCH;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    // State, PC, request and delivered-instruction registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0000_0000;
            r_pc_out   <= 32'h0000_0000;
            r_pc_plus4 <= 32'h0000_0004;
            r_count    <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            // DROP keeps presenting the abandoned address until its ack.
            if (w_state_nxt == DROP) begin
                r_addr <= r_addr;
            end else begin
                r_addr <= w_pc_nxt;
            end
            r_req   <= (w_state_nxt != HOLD);
            r_valid <= (w_state_nxt == HOLD);
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_pc_out   <= r_pc;
                r_pc_plus4 <= r_pc + 32'd4;
            end else begin
                r_instr    <= r_instr;
                r_pc_out   <= r_pc_out;
                r_pc_plus4 <= r_pc_plus4;
            end
            if (w_count_inc) begin
                r_count <= r_count + 32'd1;
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_plus4;
    assign instr_count = r_count;
    // Flagged in the redirect cycle itself, hence not registered.
    assign misalign    = RST_N & redirect_valid & (redirect_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a transaction-level model.
module tb_fetch_unit;

    logic        CLK;
    logic        RST_N;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .misalign       (misalign),
        .instr_count    (instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_started : reset released and at least one clock seen
    // m_valid   : a word is waiting for the decoder
    // m_discard : the in-flight request belongs to a superseded stream
    // m_addr    : address of the in-flight request; m_pc : where to go after a discard
    logic        m_started, m_valid, m_discard;
    logic [31:0] m_addr, m_pc, m_instr, m_pcout, m_count;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_started <= 1'b0;
            m_valid   <= 1'b0;
            m_discard <= 1'b0;
            m_addr    <= 32'h0;
            m_pc      <= 32'h0;
            m_instr   <= 32'h0;
            m_pcout   <= 32'h0;
            m_count   <= 32'h0;
        end else begin
            m_started <= 1'b1;
            if (m_valid) begin
                if (redirect_valid || instr_ready) begin
                    if (instr_ready) m_count <= m_count + 32'd1;
                    m_valid <= 1'b0;
                    m_addr  <= redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_pcout + 32'd4;
                    m_pc    <= redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_pcout + 32'd4;
                end
            end else if (redirect_valid) begin
                m_pc <= redirect_pc & 32'hFFFF_FFFC;
                if (m_started && !imem_ack) begin
                    m_discard <= 1'b1;
                end else begin
                    m_discard <= 1'b0;
                    m_addr    <= redirect_pc & 32'hFFFF_FFFC;
                end
            end else if (m_started && imem_ack) begin
                if (m_discard) begin
                    m_discard <= 1'b0;
                    m_addr    <= m_pc;
                end else begin
                    m_valid <= 1'b1;
                    m_instr <= imem_rdata;
                    m_pcout <= m_addr;
                end
            end
        end
    end

    // Compare DUT outputs against the model once per cycle, mid-cycle.
    always @(negedge CLK) begin
        logic exp_req;
        exp_req = m_started && !m_valid;
        chk("m_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("m_addr", imem_addr, m_addr);
        chk("m_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("m_instr", instr, m_instr);
        chk("m_pc_out", pc_out, m_pcout);
        chk("m_pc_plus4", pc_plus4, m_pcout + 32'd4);
        chk("m_count", instr_count, m_count);
        chk("m_misalign", {31'd0, misalign},
            {31'd0, RST_N && redirect_valid && (redirect_pc[1:0] != 2'b00)});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        chk("rst_count", instr_count, 32'd0);
        do_reset();

        // Back-to-back fetches with immediate ack and ready
        imem_ack = 1'b1;
        imem_rdata = 32'hA5A5_0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("seq_req", {31'd0, imem_req}, 32'd1);
            chk("seq_addr", imem_addr, 32'(i * 4));
            tick();
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            chk("seq_pc_out", pc_out, 32'(i * 4));
            tick();
        end
        chk("seq_count", instr_count, 32'd4);
        imem_ack = 1'b0;

        // Slow memory: ack three cycles late
        instr_ready = 1'b0;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                imem_ack = 1'b1;
                imem_rdata = 32'h8C01_0001;
            end
            chk("slow_req", {31'd0, imem_req}, 32'd1);
            chk("slow_addr", imem_addr, 32'd0);
            tick();
        end
        imem_ack = 1'b0;
        chk("slow_valid", {31'd0, instr_valid}, 32'd1);
        chk("slow_instr", instr, 32'h8C01_0001);
        chk("slow_pc_plus4", pc_plus4, 32'd4);

        // Decoder stall
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, 32'h8C01_0001);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("stall_count", instr_count, 32'd1);
        chk("stall_next_addr", imem_addr, 32'd4);

        // Redirect while the fetch of 8 is outstanding
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("drop_pre_addr", imem_addr, 32'd8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drop_req", {31'd0, imem_req}, 32'd1);
            chk("drop_addr_hold", imem_addr, 32'd8);
            chk("drop_valid", {31'd0, instr_valid}, 32'd0);
            if (k == 0) tick();
        end
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("drop_new_addr", imem_addr, 32'h40);
        chk("drop_valid2", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("drop_valid3", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_1234;
        tick();
        imem_ack = 1'b0;
        chk("drop_instr", instr, 32'h0000_1234);
        chk("drop_pc_out", pc_out, 32'h40);

        // Misaligned redirect from HOLD with the decoder stalled
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        #1;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_count", instr_count, 32'd2);

        // Reset in DROP
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rdrop_req", {31'd0, imem_req}, 32'd0);
        chk("rdrop_count", instr_count, 32'd0);
        chk("rdrop_pc_plus4", pc_plus4, 32'd4);
        tick();
        RST_N = 1'b1;
        tick();
        chk("rdrop_addr", imem_addr, 32'd0);
        chk("rdrop_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'h5555_5555;
        tick();
        imem_ack = 1'b0;
        chk("rdrop_instr", instr, 32'h5555_5555);
        chk("rdrop_pc_out", pc_out, 32'd0);

        // Redirect coinciding with ack, then PC wrap
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        imem_ack = 1'b1;
        imem_rdata = 32'h6666_6666;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        chk("wrap_valid", {31'd0, instr_valid}, 32'd0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        imem_rdata = 32'h7777_7777;
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_next_addr", imem_addr, 32'd0);
        chk("wrap_count", instr_count, 32'd2);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            imem_ack    = ($urandom_range(0, 1) == 1);
            imem_rdata  = $urandom;
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFFC;
                1:       redirect_pc = 32'hFFFF_FFFF;
                default: redirect_pc = $urandom;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                RST_N = 1'b0;
                tick();
                RST_N = 1'b1;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
